// File: rtl/r_fifo_pkg.sv
// Shared types for the AXI read-data buffer: RRESP encodings, entry layout, pointer sizing.
package r_fifo_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } rresp_e;

  localparam int R_DATA_W = 32;
  localparam int R_ID_W   = 4;

  // Field order here is the packing order used by the buffer storage.
  typedef struct packed {
    logic [R_ID_W-1:0]   id;
    logic [R_DATA_W-1:0] data;
    logic [1:0]          resp;
    logic                last;
  } r_entry_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/r_fifo_mem.sv
// Purpose: dual-port storage, synchronous write, asynchronous read, no reset.
// Latency: write visible on read port the cycle after the write edge.
// Backpressure: none; the caller gates wr_en.
module r_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 39
) (
  input  logic                     wr_clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_dat,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_dat
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge wr_clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
  end

  assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/r_fifo_buffer.sv
// Purpose: FWFT buffer for AXI read beats; define R_FIFO_BURST_CNT_EN to track held complete bursts.
// Latency: 1 cycle from push edge to out_fifo_RVALID; no bypass.
// Backpressure: in_fifo_RREADY = !full; push on a full+pop cycle waits for the next edge.
module r_fifo_buffer
  import r_fifo_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                          R_fifo_clk,
  input  logic                          R_fifo_rst_n,
  input  logic [DATA_WIDTH-1:0]         in_fifo_RDATA,
  input  logic [1:0]                    in_fifo_RRESP,
  input  logic                          in_fifo_RLAST,
  input  logic [ID_WIDTH-1:0]           in_fifo_RID,
  input  logic                          in_fifo_RVALID,
  output logic                          in_fifo_RREADY,
  output logic [DATA_WIDTH-1:0]         out_fifo_RDATA,
  output logic [1:0]                    out_fifo_RRESP,
  output logic                          out_fifo_RLAST,
  output logic [ID_WIDTH-1:0]           out_fifo_RID,
  output logic                          out_fifo_RVALID,
  input  logic                          out_fifo_RREADY,
  output logic                          R_fifo_full,
  output logic                          R_fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   R_fifo_count,
  output logic [$clog2(FIFO_DEPTH):0]   R_fifo_bursts
);

  localparam int PW = ptr_w(FIFO_DEPTH);
  localparam int AW = PW - 1;
  localparam int EW = ID_WIDTH + DATA_WIDTH + 2 + 1;

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;
  logic [EW-1:0] wr_dat, rd_dat;

  // Extra MSB on each pointer distinguishes full from empty when low bits match.
  assign R_fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign R_fifo_empty = (wr_ptr == rd_ptr);
  assign R_fifo_count = wr_ptr - rd_ptr;

  assign in_fifo_RREADY  = !R_fifo_full;
  assign out_fifo_RVALID = !R_fifo_empty;

  assign push = in_fifo_RVALID && in_fifo_RREADY;
  assign pop  = out_fifo_RVALID && out_fifo_RREADY;

  always_ff @(posedge R_fifo_clk or negedge R_fifo_rst_n) begin
    if (!R_fifo_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign wr_dat = {in_fifo_RID, in_fifo_RDATA, in_fifo_RRESP, in_fifo_RLAST};
  assign {out_fifo_RID, out_fifo_RDATA, out_fifo_RRESP, out_fifo_RLAST} = rd_dat;

  r_fifo_mem #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_mem (
    .wr_clk  (R_fifo_clk),
    .wr_en   (push),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_dat  (wr_dat),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_dat  (rd_dat)
  );

`ifdef R_FIFO_BURST_CNT_EN
  logic [PW-1:0] bursts_q;
  logic          burst_in, burst_out;

  assign burst_in  = push && in_fifo_RLAST;
  assign burst_out = pop && out_fifo_RLAST;

  always_ff @(posedge R_fifo_clk or negedge R_fifo_rst_n) begin
    if (!R_fifo_rst_n) begin
      bursts_q <= '0;
    end else if (burst_in && !burst_out) begin
      bursts_q <= bursts_q + 1'b1;
    end else if (burst_out && !burst_in) begin
      bursts_q <= bursts_q - 1'b1;
    end
  end

  assign R_fifo_bursts = bursts_q;
`else
  assign R_fifo_bursts = '0;
`endif

endmodule

// File: tb/tb_r_fifo_buffer.sv
// Directed bench for r_fifo_buffer: vector table plus fill, wrap, reset and error-passthrough sequences.
module tb_r_fifo_buffer;
  import r_fifo_pkg::*;

`ifdef R_FIFO_BURST_CNT_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_rdata;
  logic [1:0]  in_rresp;
  logic        in_rlast;
  logic [3:0]  in_rid;
  logic        in_rvalid;
  logic        in_rready;
  logic [31:0] out_rdata;
  logic [1:0]  out_rresp;
  logic        out_rlast;
  logic [3:0]  out_rid;
  logic        out_rvalid;
  logic        out_rready;
  logic        full, empty;
  logic [4:0]  count, bursts;

  r_entry_t out_e;
  assign out_e = {out_rid, out_rdata, out_rresp, out_rlast};

  always #5 clk = ~clk;

  r_fifo_buffer dut (
    .R_fifo_clk      (clk),
    .R_fifo_rst_n    (rst_n),
    .in_fifo_RDATA   (in_rdata),
    .in_fifo_RRESP   (in_rresp),
    .in_fifo_RLAST   (in_rlast),
    .in_fifo_RID     (in_rid),
    .in_fifo_RVALID  (in_rvalid),
    .in_fifo_RREADY  (in_rready),
    .out_fifo_RDATA  (out_rdata),
    .out_fifo_RRESP  (out_rresp),
    .out_fifo_RLAST  (out_rlast),
    .out_fifo_RID    (out_rid),
    .out_fifo_RVALID (out_rvalid),
    .out_fifo_RREADY (out_rready),
    .R_fifo_full     (full),
    .R_fifo_empty    (empty),
    .R_fifo_count    (count),
    .R_fifo_bursts   (bursts)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic r_entry_t mk(input logic [3:0] id, input logic [31:0] d,
                                  input logic [1:0] r, input logic l);
    r_entry_t e;
    e.id = id; e.data = d; e.resp = r; e.last = l;
    return e;
  endfunction

  function automatic int bexp(input int b);
    return BURST_EN ? b : 0;
  endfunction

  task automatic drive(input logic vld, input r_entry_t e, input logic rdy);
    in_rvalid  = vld;
    in_rid     = e.id;
    in_rdata   = e.data;
    in_rresp   = e.resp;
    in_rlast   = e.last;
    out_rready = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  function automatic r_entry_t wb(input int k);
    return mk(k[3:0], 32'hA500_0000 + k * 3, k[1:0], (k % 5) == 4);
  endfunction

  typedef struct {
    logic     vld;
    r_entry_t beat;
    logic     rdy;
    int       e_cnt;
    int       e_bursts;
    logic     e_ovld;
    r_entry_t e_head;
  } vec_t;

  vec_t vecs[7];

  initial begin
    r_entry_t e0, e1, e2, z, x;
    e0 = mk(4'd3, 32'hDEADBEEF, RESP_OKAY, 1'b1);
    e1 = mk(4'd1, 32'h1111_1111, RESP_OKAY, 1'b0);
    e2 = mk(4'd2, 32'h2222_2222, RESP_EXOKAY, 1'b1);
    z  = '0;
    vecs[0] = '{1'b1, e0, 1'b0, 1, 1, 1'b1, e0};
    vecs[1] = '{1'b0, z,  1'b0, 1, 1, 1'b1, e0};
    vecs[2] = '{1'b1, e1, 1'b1, 1, 0, 1'b1, e1};
    vecs[3] = '{1'b1, e2, 1'b0, 2, 1, 1'b1, e1};
    vecs[4] = '{1'b0, z,  1'b1, 1, 1, 1'b1, e2};
    vecs[5] = '{1'b0, z,  1'b1, 0, 0, 1'b0, z};
    vecs[6] = '{1'b0, z,  1'b1, 0, 0, 1'b0, z};

    // Reset values, sampled before any clock edge.
    rst_n = 1'b1;
    drive(1'b0, '0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_in_rdy", in_rready, 1);
    chk("rst_out_vld", out_rvalid, 0);
    chk("rst_count", count, 0);
    chk("rst_bursts", bursts, 0);
    do_reset();

    foreach (vecs[i]) begin
      drive(vecs[i].vld, vecs[i].beat, vecs[i].rdy);
      if (i == 0) begin
        #1 chk("no_bypass", out_rvalid, 0);
      end
      step();
      chk("vec_count", count, vecs[i].e_cnt);
      chk("vec_bursts", bursts, bexp(vecs[i].e_bursts));
      chk("vec_out_vld", out_rvalid, vecs[i].e_ovld);
      chk("vec_empty", empty, vecs[i].e_cnt == 0);
      chk("vec_in_rdy", in_rready, 1);
      if (vecs[i].e_ovld) chk("vec_head", out_e, vecs[i].e_head);
    end

    // Fill to full, offer a 17th beat, then a full+pop cycle.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, mk(i[3:0], 32'h100 + i, RESP_OKAY, (i % 4) == 3), 1'b0);
      step();
    end
    chk("fill_full", full, 1);
    chk("fill_in_rdy", in_rready, 0);
    chk("fill_count", count, 16);
    chk("fill_bursts", bursts, bexp(4));
    x = mk(4'hA, 32'h200, RESP_DECERR, 1'b1);
    drive(1'b1, x, 1'b0);
    step();
    chk("fill_17th_ignored", count, 16);
    drive(1'b1, x, 1'b1);
    step();
    chk("fullpop_count", count, 15);
    chk("fullpop_head", out_e, mk(4'd1, 32'h101, RESP_OKAY, 1'b0));
    chk("fullpop_in_rdy", in_rready, 1);
    drive(1'b1, x, 1'b0);
    step();
    chk("fullpush_count", count, 16);
    chk("fullpush_bursts", bursts, bexp(5));
    drive(1'b0, '0, 1'b1);
    for (int k = 0; k < 16; k++) begin
      chk("drain_head", out_e, (k < 15) ? mk(k[3:0] + 4'd1, 32'h101 + k, RESP_OKAY, (k % 4) == 2) : x);
      step();
    end
    chk("drain_empty", empty, 1);

    // Random valid/ready stream that wraps the pointers.
    begin
      int sent, recv, cyc;
      logic fire, pop;
      sent = 0; recv = 0; cyc = 0;
      do_reset();
      while (recv < 40 && cyc < 2000) begin
        drive((sent < 40) && ($urandom_range(0, 2) != 0), wb(sent), $urandom_range(0, 2) != 0);
        @(negedge clk);
        fire = in_rvalid && in_rready;
        pop  = out_rvalid && out_rready;
        if (pop) chk("wrap_beat", out_e, wb(recv));
        step();
        if (fire) sent++;
        if (pop) recv++;
        cyc++;
      end
      chk("wrap_recv", recv, 40);
      drive(1'b0, '0, 1'b0);
      chk("wrap_empty", empty, 1);
    end

    // Reset asserted mid-burst takes effect without a clock edge.
    do_reset();
    drive(1'b1, mk(4'd5, 32'h55, RESP_OKAY, 1'b1), 1'b0);
    step();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, mk(4'd6, 32'h600 + i, RESP_OKAY, 1'b0), 1'b0);
      step();
    end
    drive(1'b0, '0, 1'b0);
    chk("pre_rst_count", count, 6);
    chk("pre_rst_bursts", bursts, bexp(1));
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_empty", empty, 1);
    chk("midrst_count", count, 0);
    chk("midrst_bursts", bursts, 0);
    chk("midrst_in_rdy", in_rready, 1);
    chk("midrst_out_vld", out_rvalid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_empty", empty, 1);

    // Error response inside a burst passes through untouched.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, mk(4'd7, 32'hE0 + k, (k == 1) ? RESP_SLVERR : RESP_OKAY, k == 3), 1'b0);
      step();
    end
    drive(1'b0, '0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk("err_beat", out_e, mk(4'd7, 32'hE0 + k, (k == 1) ? RESP_SLVERR : RESP_OKAY, k == 3));
      step();
    end
    chk("err_empty", empty, 1);
    chk("err_bursts", bursts, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
